// File: rtl/pe_input_skewer_if.sv
// Word stream from the activation buffer into pe_input_skewer.
// The master drives word/valid; the skewer answers with ready.
interface pe_input_skewer_if #(
  parameter int BUFFER_WORD_SIZE = 16
) ();
  logic [BUFFER_WORD_SIZE-1:0] in_word;
  logic                        in_valid;
  logic                        in_ready;

  modport master (
    output in_word,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_word,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/pe_input_skewer.sv
// Unpacks buffer words into vectors and feeds them row-skewed into the array.
// Define PE_SKEW_ZERO_FILL_EN to drive zeros on bubble slots instead of holding.
module pe_input_skewer #(
  parameter int ARRAY_SIZE         = 8,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int BUFFER_WORD_SIZE   = 16,
  parameter int NUM_COMPUTE_LANES  = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH,
  parameter int WORDS_PER_VEC      = ARRAY_SIZE / NUM_COMPUTE_LANES,
  parameter int COUNT_WIDTH        = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [COUNT_WIDTH-1:0]               vec_count,
  pe_input_skewer_if.slave                     in_if,
  output logic signed [COMPUTE_DATA_WIDTH-1:0] row_data_arr [ARRAY_SIZE-1:0],
  output logic [ARRAY_SIZE-1:0]                row_valid,
  output logic                                 compute,
  output logic                                 busy,
  output logic                                 done
);

  localparam int W   = COMPUTE_DATA_WIDTH;
  localparam int L   = NUM_COMPUTE_LANES;
  localparam int WIW = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1;
  localparam int DCW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
`ifdef PE_SKEW_ZERO_FILL_EN
  localparam bit ZERO_FILL = 1'b1;
`else
  localparam bit ZERO_FILL = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] vec_idx_q, vec_idx_d;
  logic [WIW-1:0]         word_idx_q, word_idx_d;
  logic [DCW-1:0]         drain_q, drain_d;
  logic [W-1:0]           slot_q [ARRAY_SIZE];
  logic [W-1:0]           slot_d [ARRAY_SIZE];
  logic                   accept;
  logic                   inject;

  assign accept = (state_q == FILL) && in_if.in_valid;
  assign inject = accept && (word_idx_q == WIW'(WORDS_PER_VEC - 1));

  assign in_if.in_ready = (state_q == FILL);
  assign busy           = (state_q != IDLE);
  assign compute        = (state_q != IDLE);
  assign done           = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_idx_d  = vec_idx_q;
    word_idx_d = word_idx_q;
    drain_d    = drain_q;
    slot_d     = slot_q;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (accept && (word_idx_q == WIW'(i / L)))
        slot_d[i] = in_if.in_word[(i % L) * W +: W];
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d      = vec_count;
          vec_idx_d  = '0;
          word_idx_d = '0;
          drain_d    = '0;
          state_d    = (vec_count == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (accept)
          word_idx_d = inject ? '0 : word_idx_q + 1'b1;
        if (inject) begin
          vec_idx_d = vec_idx_q + 1'b1;
          if (vec_idx_q == cnt_q - 1'b1) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        // Last injection sits at stage 0; wait until row ARRAY_SIZE-1 emitted it.
        if (drain_q == DCW'(ARRAY_SIZE - 1))
          state_d = DONE;
        else
          drain_d = drain_q + 1'b1;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      vec_idx_q  <= '0;
      word_idx_q <= '0;
      drain_q    <= '0;
      for (int i = 0; i < ARRAY_SIZE; i++)
        slot_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vec_idx_q  <= vec_idx_d;
      word_idx_q <= word_idx_d;
      drain_q    <= drain_d;
      slot_q     <= slot_d;
    end
  end

  function automatic logic [W-1:0] nxt_dat(
    input logic         v,
    input logic [W-1:0] din,
    input logic [W-1:0] hold
  );
    if (v)
      return din;
    return ZERO_FILL ? '0 : hold;
  endfunction

  // Row r: injection register (stage 0) followed by r delay stages.
  for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
    logic [W-1:0] dat_q [0:r];
    logic [W-1:0] dat_d [0:r];
    logic [r:0]   vld_q, vld_d;

    always_comb begin
      vld_d    = vld_q;
      dat_d    = dat_q;
      vld_d[0] = inject;
      dat_d[0] = nxt_dat(inject, slot_d[r], dat_q[0]);
      for (int k = 1; k <= r; k++) begin
        vld_d[k] = vld_q[k-1];
        dat_d[k] = nxt_dat(vld_q[k-1], dat_q[k-1], dat_q[k]);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= '0;
        for (int k = 0; k <= r; k++)
          dat_q[k] <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign row_valid[r]    = vld_q[r];
    assign row_data_arr[r] = dat_q[r];
  end

endmodule

// File: tb/tb_pe_input_skewer.sv
// Randomized bench for pe_input_skewer against a cycle-scheduled event model.
// Build with PE_SKEW_ZERO_FILL_EN to check the zero-fill variant.
module tb_pe_input_skewer;
  localparam int N  = 8;
  localparam int W  = 4;
  localparam int LN = 4;
`ifdef PE_SKEW_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  vec_count = '0;
  logic signed [W-1:0] row_data_arr [N-1:0];
  logic [N-1:0] row_valid;
  logic        compute, busy, done;

  pe_input_skewer_if #(.BUFFER_WORD_SIZE(16)) bus ();

  pe_input_skewer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vec_count    (vec_count),
    .in_if        (bus),
    .row_data_arr (row_data_arr),
    .row_valid    (row_valid),
    .compute      (compute),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: expected row events per cycle, kept in a 16-deep ring.
  int cyc = 0;
  bit m_busy, m_fill;
  int m_n, m_words, m_done_cyc, m_end_cyc;
  int elems [N];
  bit rv [16][N];
  int rd [16][N];
  int hold [N];
  logic [15:0] wq [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    m_busy = 0;
    m_fill = 0;
    m_words = 0;
    m_done_cyc = -1;
    m_end_cyc = -1;
    for (int s = 0; s < 16; s++)
      for (int r = 0; r < N; r++) begin
        rv[s][r] = 0;
        rd[s][r] = 0;
      end
    for (int r = 0; r < N; r++)
      hold[r] = 0;
  endtask

  task automatic model_step();
    int base;
    if (!rst) begin
      model_clear();
      return;
    end
    if (m_busy && cyc == m_end_cyc) begin
      m_busy = 0;
    end else if (!m_busy && start) begin
      m_busy = 1;
      m_n = int'(vec_count);
      m_words = 0;
      m_done_cyc = -1;
      m_end_cyc = -1;
      if (m_n == 0) begin
        m_fill = 0;
        m_done_cyc = cyc;
        m_end_cyc = cyc + 1;
      end else begin
        m_fill = 1;
      end
    end else if (m_fill && bus.in_valid) begin
      base = (m_words % 2) * LN;
      for (int l = 0; l < LN; l++)
        elems[base + l] = int'((bus.in_word >> (l * W)) & 16'hF);
      m_words++;
      if (m_words % 2 == 0) begin
        for (int r = 0; r < N; r++) begin
          rv[(cyc + r) % 16][r] = 1;
          rd[(cyc + r) % 16][r] = elems[r];
        end
        if (m_words == 2 * m_n) begin
          m_fill = 0;
          m_done_cyc = cyc + N;
          m_end_cyc = cyc + N + 1;
        end
      end
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0]   ev, gv;
    logic [31:0]    ed, gd;
    int s;
    for (int r = 0; r < N; r++)
      gd[r*W +: W] = row_data_arr[r];
    gv = row_valid;
    if (!rst) begin
      for (int r = 0; r < N; r++)
        hold[r] = 0;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_compute", {31'b0, compute}, 32'd0);
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_row_valid", {24'b0, gv}, 32'd0);
      check("rst_row_data", gd, 32'd0);
      return;
    end
    s = cyc % 16;
    ev = '0;
    ed = '0;
    for (int r = 0; r < N; r++) begin
      if (rv[s][r]) begin
        ev[r] = 1'b1;
        hold[r] = rd[s][r];
        ed[r*W +: W] = 4'(rd[s][r]);
      end else begin
        ed[r*W +: W] = ZF ? 4'h0 : 4'(hold[r]);
      end
      rv[s][r] = 0;
    end
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("compute", {31'b0, compute}, {31'b0, m_busy});
    check("in_ready", {31'b0, bus.in_ready}, {31'b0, m_fill});
    check("done", {31'b0, done}, {31'b0, m_busy && cyc == m_done_cyc});
    check("row_valid", {24'b0, gv}, {24'b0, ev});
    check("row_data", gd, ed);
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check_cycle();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    vec_count = 8'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int nw, input int gap_at, input int gap_len,
                      input bit rnd, input bit mid);
    int t;
    int g;
    for (int i = 0; i < nw; i++) begin
      if (i == gap_at) begin
        bus.in_valid = 1'b0;
        repeat (gap_len) tick();
      end
      g = 0;
      while (rnd && g < 4 && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        tick();
        g++;
      end
      bus.in_word = wq[i];
      bus.in_valid = 1'b1;
      t = 0;
      while (m_words <= i && t < 20) begin
        tick();
        t++;
      end
      if (m_words <= i)
        check("accept_timeout", 32'd0, 32'd1);
      if (mid && i == 0) begin
        bus.in_valid = 1'b0;
        start = 1'b1;
        vec_count = 8'd7;
        tick();
        start = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (m_busy && t < 100) begin
      tick();
      t++;
    end
    if (m_busy)
      check("idle_timeout", 32'd1, 32'd0);
    tick();
  endtask

  task automatic run(input int n, input int gap_at, input int gap_len,
                     input bit rnd, input bit mid);
    do_start(n);
    feed(2 * n, gap_at, gap_len, rnd, mid);
    wait_idle();
  endtask

  task automatic fill_rand(input int nw);
    wq.delete();
    for (int i = 0; i < nw; i++)
      wq.push_back(16'($urandom));
  endtask

  initial begin
    int n;
    bus.in_word = '0;
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    wq.delete();
    wq.push_back(16'h4321);
    wq.push_back(16'h8765);
    run(1, -1, 0, 1'b0, 1'b0);

    fill_rand(8);
    run(4, -1, 0, 1'b0, 1'b0);

    fill_rand(4);
    run(2, 3, 3, 1'b0, 1'b0);

    wq.delete();
    run(0, -1, 0, 1'b0, 1'b0);

    fill_rand(6);
    run(3, -1, 0, 1'b0, 1'b1);

    fill_rand(6);
    do_start(3);
    feed(3, -1, 0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    wq.delete();
    wq.push_back(16'h1234);
    wq.push_back(16'hfedc);
    run(1, -1, 0, 1'b0, 1'b0);

    repeat (6) begin
      n = $urandom_range(1, 5);
      fill_rand(2 * n);
      run(n, -1, 0, 1'b1, 1'b0);
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
